// File: rtl/tcp_tx_arbiter_if.sv
// Handshake bundle between the packet sources, tcp_tx_arbiter and tcp_sender.
// master = arbiter side, slave = sources / sender side.
interface tcp_tx_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int PKT_W = 312
);
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*PKT_W-1:0] req_pkt;
   logic [N_REQ-1:0]       req_ack;
   logic [N_REQ-1:0]       req_done;
   logic [N_REQ-1:0]       req_err;
   logic                   tx_start;
   logic [PKT_W-1:0]       tx_pkt;
   logic                   tx_busy;
   logic [N_REQ-1:0]       grant;
   logic [IDX_W-1:0]       grant_idx;
   logic                   active;
   logic [15:0]            frame_cnt;

   modport master (
      input  req, req_pkt, tx_busy,
      output req_ack, req_done, req_err, tx_start, tx_pkt,
             grant, grant_idx, active, frame_cnt
   );

   modport slave (
      output req, req_pkt, tx_busy,
      input  req_ack, req_done, req_err, tx_start, tx_pkt,
             grant, grant_idx, active, frame_cnt
   );
endinterface

// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter sharing one tcp_sender among N_REQ packet sources, one frame at a time.
// Define TCP_TX_ARB_PRIO0_EN to give source 0 strict priority over the rotating others.
module tcp_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   tcp_tx_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int PKT_W = 312;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_START     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [1:0]       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] win_idx;
   logic [N_REQ-1:0] win_oh;
   logic [IDX_W-1:0] next_ptr;
   logic             any_req;
   logic             adv_ptr;
   logic [7:0]       busy_cnt;

   function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   assign any_req = |bus.req;
   assign win_oh  = N_REQ'(1) << win_idx;

   // Scan downwards so the last hit is the first set bit at or after rr_ptr.
   always_comb begin
      // NOTE: win_idx gets a default before any conditional write, so no latch is inferred.
      win_idx = rr_ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req[wrap_idx(rr_ptr, k)]) win_idx = wrap_idx(rr_ptr, k);
      end
`ifdef TCP_TX_ARB_PRIO0_EN
      if (bus.req[0]) win_idx = '0;
`endif
   end

   assign next_ptr = (bus.grant_idx == IDX_W'(N_REQ - 1)) ? '0 : bus.grant_idx + IDX_W'(1);

`ifdef TCP_TX_ARB_PRIO0_EN
   // Source-0 frames must not disturb the rotation among the other sources.
   assign adv_ptr = (bus.grant_idx != '0);
`else
   assign adv_ptr = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: tx_pkt is a plain register, not a memory, so it is cleared with everything else.
         state         <= S_IDLE;
         rr_ptr        <= '0;
         busy_cnt      <= '0;
         bus.req_ack   <= '0;
         bus.req_done  <= '0;
         bus.req_err   <= '0;
         bus.tx_start  <= 1'b0;
         bus.tx_pkt    <= '0;
         bus.grant     <= '0;
         bus.grant_idx <= '0;
         bus.active    <= 1'b0;
         bus.frame_cnt <= '0;
      end else begin
         // NOTE: non-blocking only; strobes default low here and the owning state overrides them.
         bus.req_ack  <= '0;
         bus.req_done <= '0;
         bus.req_err  <= '0;
         bus.tx_start <= 1'b0;

         case (state)
            S_IDLE: begin
               if (any_req) begin
                  bus.tx_pkt    <= bus.req_pkt[int'(win_idx)*PKT_W +: PKT_W];
                  bus.grant     <= win_oh;
                  bus.grant_idx <= win_idx;
                  bus.req_ack   <= win_oh;
                  bus.active    <= 1'b1;
                  state         <= S_START;
               end
            end

            S_START: begin
               bus.tx_start <= 1'b1;
               busy_cnt     <= '0;
               state        <= S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state <= S_WAIT_DONE;
               end else if (busy_cnt == 8'(BUSY_TIMEOUT - 1)) begin
                  // Sender never took the frame: abort, and the source loses its turn.
                  bus.req_err   <= bus.grant;
                  bus.grant     <= '0;
                  bus.grant_idx <= '0;
                  bus.active    <= 1'b0;
                  if (adv_ptr) rr_ptr <= next_ptr;
                  state         <= S_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 8'd1;
               end
            end

            S_WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  bus.req_done  <= bus.grant;
                  bus.frame_cnt <= bus.frame_cnt + 16'd1;
                  bus.grant     <= '0;
                  bus.grant_idx <= '0;
                  bus.active    <= 1'b0;
                  if (adv_ptr) rr_ptr <= next_ptr;
                  state         <= S_IDLE;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter with a simple tcp_sender busy model.
// Follows TCP_TX_ARB_PRIO0_EN the same way the design does.
module tb_tcp_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;
   localparam int K_ACK  = 0;
   localparam int K_DONE = 1;
   localparam int K_ERR  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic model_busy;
   int   busy_left;
   logic busy_en = 1'b1;
   logic force_busy = 1'b0;
   int   busy_len = 60;

   int checks = 0;
   int errors = 0;

   int ack_cnt  [N] = '{default: 0};
   int done_cnt [N] = '{default: 0};
   int start_cnt = 0;
   int wide_cnt  = 0;
   logic start_prev = 1'b0;

   tcp_tx_arbiter_if #(.N_REQ(N)) bus ();

   tcp_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Sender model: busy rises the cycle after start and stays up busy_len cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_busy <= 1'b0;
         busy_left  <= 0;
      end else if (model_busy) begin
         if (busy_left <= 1) model_busy <= 1'b0;
         busy_left <= busy_left - 1;
      end else if (bus.tx_start && busy_en) begin
         model_busy <= 1'b1;
         busy_left  <= busy_len;
      end
   end
   assign bus.tx_busy = model_busy | force_busy;

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (bus.req_ack[i])  ack_cnt[i]++;
         if (bus.req_done[i]) done_cnt[i]++;
      end
      if (bus.tx_start) begin
         start_cnt++;
         if (start_prev) wide_cnt++;
      end
      start_prev = bus.tx_start;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_for(input string tag, input int kind, input logic [N-1:0] exp,
                           input int budget, output int cycles);
      logic [N-1:0] seen;
      seen   = '0;
      cycles = 0;
      while (seen == '0 && cycles < budget) begin
         @(negedge clk);
         cycles++;
         case (kind)
            K_ACK:   seen = bus.req_ack;
            K_DONE:  seen = bus.req_done;
            default: seen = bus.req_err;
         endcase
      end
      check(tag, seen, exp);
   endtask

   task automatic do_reset();
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [311:0] mk_pkt(input int i);
      logic [15:0] sp;
      sp = (i == 2) ? 16'h1234 : 16'h1000 + 16'(i);
      return {{8{32'hC0DE_0000 | 32'(i)}}, 40'(i), sp};
   endfunction

   initial begin
      int cyc;
      int s0, a0, d0, w0;
      logic [N-1:0] one;
      one = 1;

      for (int i = 0; i < N; i++) bus.req_pkt[i*312 +: 312] = mk_pkt(i);

      // Reset with every source requesting
      bus.req = 4'b1111;
      repeat (3) @(negedge clk);
      check("rst_grant", bus.grant, 0);
      check("rst_ack", bus.req_ack, 0);
      check("rst_start", bus.tx_start, 0);
      check("rst_active", bus.active, 0);
      check("rst_frame_cnt", bus.frame_cnt, 0);
      check("rst_tx_pkt", bus.tx_pkt, 0);
      check("rst_idx", bus.grant_idx, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_first_grant", bus.grant, 4'b0001);
      check("rst_start_late", bus.tx_start, 0);
      bus.req = '0;
      @(negedge clk);
      check("rst_start_next", bus.tx_start, 1);
      wait_for("rst_done", K_DONE, 4'b0001, 200, cyc);
      check("rst_frame_one", bus.frame_cnt, 1);

      // Single request from source 2
      do_reset();
      s0 = start_cnt; a0 = ack_cnt[2]; d0 = done_cnt[2]; w0 = wide_cnt;
      bus.req = 4'b0100;
      wait_for("single_ack", K_ACK, 4'b0100, 10, cyc);
      check("single_ack_lat", cyc, 1);
      bus.req = '0;
      check("single_pkt", bus.tx_pkt, mk_pkt(2));
      check("single_src_port", bus.tx_pkt[15:0], 16'h1234);
      check("single_idx", bus.grant_idx, 2);
      wait_for("single_done", K_DONE, 4'b0100, 200, cyc);
      check("single_frame_cnt", bus.frame_cnt, 1);
      check("single_grant_clr", bus.grant, 0);
      check("single_active_clr", bus.active, 0);
      @(negedge clk);
      check("single_ack_once", ack_cnt[2] - a0, 1);
      check("single_done_once", done_cnt[2] - d0, 1);
      check("single_start_once", start_cnt - s0, 1);
      check("single_start_width", wide_cnt - w0, 0);
      check("single_pkt_hold", bus.tx_pkt, mk_pkt(2));

`ifndef TCP_TX_ARB_PRIO0_EN
      // Round-robin with all sources held, including the wrap back to 0
      do_reset();
      busy_len = 6;
      bus.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_for($sformatf("rr_ack%0d", k), K_ACK, one << (k % N), 50, cyc);
         check($sformatf("rr_gap%0d", k), cyc, 1);
         check($sformatf("rr_idx%0d", k), bus.grant_idx, k % N);
         if (k == 4) bus.req = '0;
         wait_for($sformatf("rr_done%0d", k), K_DONE, one << (k % N), 50, cyc);
         if (k == 3) check("rr_frame_cnt4", bus.frame_cnt, 4);
      end
      check("rr_frame_cnt5", bus.frame_cnt, 5);
      busy_len = 60;
`endif

      // Sender never raises busy
      do_reset();
      busy_en = 1'b0;
      bus.req = 4'b0010;
      wait_for("to_ack", K_ACK, 4'b0010, 10, cyc);
      bus.req = '0;
      @(negedge clk);
      check("to_start", bus.tx_start, 1);
      wait_for("to_err", K_ERR, 4'b0010, 40, cyc);
      check("to_latency", cyc, TO);
      check("to_frame_cnt", bus.frame_cnt, 0);
      check("to_grant", bus.grant, 0);
      check("to_active", bus.active, 0);
      busy_en = 1'b1;

      // Busy while idle must not start anything
      s0 = start_cnt;
      force_busy = 1'b1;
      repeat (5) @(negedge clk);
      force_busy = 1'b0;
      @(negedge clk);
      check("idle_busy_start", start_cnt - s0, 0);
      check("idle_busy_active", bus.active, 0);

      // Reset in the middle of a frame
      do_reset();
      bus.req = 4'b0001;
      wait_for("mr_ack0", K_ACK, 4'b0001, 10, cyc);
      bus.req = '0;
      wait_for("mr_done0", K_DONE, 4'b0001, 200, cyc);
      bus.req = 4'b1000;
      wait_for("mr_ack3", K_ACK, 4'b1000, 10, cyc);
      bus.req = '0;
      cyc = 0;
      while (!bus.tx_busy && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check("mr_busy_seen", bus.tx_busy, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_grant", bus.grant, 0);
      check("mr_active", bus.active, 0);
      check("mr_tx_pkt", bus.tx_pkt, 0);
      check("mr_frame_cnt", bus.frame_cnt, 0);
      check("mr_idx", bus.grant_idx, 0);
      bus.req = 4'b1001;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_regrant", bus.grant, 4'b0001);
      bus.req = 4'b1000;
      wait_for("mr_done_after", K_DONE, 4'b0001, 200, cyc);
      bus.req = '0;
      @(negedge clk);

`ifdef TCP_TX_ARB_PRIO0_EN
      // Source 0 pre-empts the rotation but does not move it
      do_reset();
      busy_len = 6;
      bus.req = 4'b1110;
      wait_for("pr_ack1", K_ACK, 4'b0010, 10, cyc);
      bus.req = 4'b1101;
      wait_for("pr_done1", K_DONE, 4'b0010, 50, cyc);
      wait_for("pr_ack0", K_ACK, 4'b0001, 10, cyc);
      check("pr_gap0", cyc, 1);
      bus.req = 4'b1100;
      wait_for("pr_done0", K_DONE, 4'b0001, 50, cyc);
      wait_for("pr_ack2", K_ACK, 4'b0100, 10, cyc);
      bus.req = 4'b1000;
      wait_for("pr_done2", K_DONE, 4'b0100, 50, cyc);
      wait_for("pr_ack3", K_ACK, 4'b1000, 10, cyc);
      bus.req = '0;
      wait_for("pr_done3", K_DONE, 4'b1000, 50, cyc);
      check("pr_frame_cnt", bus.frame_cnt, 4);
      busy_len = 60;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
